// File: rtl/memory_game_ctrl_pkg.sv
// memgame_pkg: shared definitions for the memory game round sequencer.
//   - state encodings (localparams) and the enum built on them
//   - BCD_W: width of a 4-digit BCD value
//   - fold_digit(): maps a 4-bit value onto a BCD digit (>= 10 folds to value-10)
// Optional feature macro used by the top: MEMGAME_TIMEOUT_EN.
package memgame_pkg;

    localparam int unsigned BCD_W = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GEN     = 3'd1;
    localparam logic [2:0] ST_SHOW    = 3'd2;
    localparam logic [2:0] ST_WAIT_IN = 3'd3;
    localparam logic [2:0] ST_CHECK   = 3'd4;
    localparam logic [2:0] ST_PASS    = 3'd5;
    localparam logic [2:0] ST_FAIL    = 3'd6;
    localparam logic [2:0] ST_END     = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_GEN     = ST_GEN,
        S_SHOW    = ST_SHOW,
        S_WAIT_IN = ST_WAIT_IN,
        S_CHECK   = ST_CHECK,
        S_PASS    = ST_PASS,
        S_FAIL    = ST_FAIL,
        S_END     = ST_END
    } state_t;

    function automatic logic [3:0] fold_digit(input logic [3:0] v);
        return (v >= 4'd10) ? (v - 4'd10) : v;
    endfunction

endpackage

// File: rtl/memory_game_ctrl_if.sv
// memory_game_ctrl_if: keyboard/display side of the round sequencer.
//   key_ready   - 1-cycle pulse, 4 digits captured by the keyboard receiver
//   key_value   - 4 BCD digits, [3:0] typed first
//   kbd_clr     - 1-cycle pulse clearing the receiver's partial entry
//   target      - current 4-digit BCD target, [3:0] typed first
//   show_target - display must show target while high
// Modports: master = keyboard/display side, slave = sequencer.
interface memory_game_ctrl_if;
    import memgame_pkg::*;

    logic             key_ready;
    logic [BCD_W-1:0] key_value;
    logic             kbd_clr;
    logic [BCD_W-1:0] target;
    logic             show_target;

    modport master (
        output key_ready,
        output key_value,
        input  kbd_clr,
        input  target,
        input  show_target
    );

    modport slave (
        input  key_ready,
        input  key_value,
        output kbd_clr,
        output target,
        output show_target
    );

endinterface

// File: rtl/memory_game_ctrl_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
// Ports: clk, rst (async, active-high, loads seed 16'hACE1), q[15:0] state.
// Maximal-length from a non-zero seed, so q is never all-zero.
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 16'hACE1;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
        end
    end

endmodule

// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl: round sequencer for the memorization game.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   start         - 1-cycle pulse, starts/restarts a game from IDLE or END
//   bus (slave)   - key_ready/key_value in, kbd_clr/target/show_target out
//   round, lives  - passes so far / remaining lives (both saturating)
//   result_pass, result_fail - high during PASS / FAIL hold
//   game_won, game_lost      - END outcome flags
//   state_dbg     - current state encoding
// Optional: define MEMGAME_TIMEOUT_EN to fail a round after TIMEOUT_CYCLES
// cycles in WAIT_IN with no accepted entry.
module memory_game_ctrl
    import memgame_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES    = 200000000,
    parameter int unsigned RESULT_CYCLES  = 100000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000000,
    parameter int unsigned NUM_ROUNDS     = 8,
    parameter int unsigned MAX_LIVES      = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    memory_game_ctrl_if.slave   bus,
    output logic [3:0]          round,
    output logic [1:0]          lives,
    output logic                result_pass,
    output logic                result_fail,
    output logic                game_won,
    output logic                game_lost,
    output logic [2:0]          state_dbg
);

    if (SHOW_CYCLES == 0 || RESULT_CYCLES == 0 || TIMEOUT_CYCLES == 0 ||
        NUM_ROUNDS == 0 || NUM_ROUNDS > 15 || MAX_LIVES == 0 || MAX_LIVES > 3) begin : g_bad_params
        $error("memory_game_ctrl: parameter out of range");
    end

    localparam int unsigned MAX_SR = (SHOW_CYCLES > RESULT_CYCLES) ? SHOW_CYCLES : RESULT_CYCLES;
`ifdef MEMGAME_TIMEOUT_EN
    localparam int unsigned MAX_CNT = (TIMEOUT_CYCLES > MAX_SR) ? TIMEOUT_CYCLES : MAX_SR;
`else
    localparam int unsigned MAX_CNT = MAX_SR;
`endif
    localparam int unsigned CW = $clog2(MAX_CNT + 1);

    state_t           state, next;
    logic [CW-1:0]    cnt;
    logic             armed;
    logic             accept;
    logic [BCD_W-1:0] target_q;
    logic [BCD_W-1:0] entry;
    logic [15:0]      rnd;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (rnd)
    );

    // armed is low only on the first WAIT_IN cycle: that cycle pulses
    // kbd_clr and ignores any key_ready, since the receiver is being cleared.
    assign accept          = (state == S_WAIT_IN) && armed && bus.key_ready;
    assign bus.kbd_clr     = (state == S_WAIT_IN) && !armed;
    assign bus.show_target = (state == S_SHOW);
    assign bus.target      = target_q;
    assign result_pass     = (state == S_PASS);
    assign result_fail     = (state == S_FAIL);
    assign state_dbg       = state;

    always_comb begin
        next = state;
        case (state)
            S_IDLE:    if (start) next = S_GEN;
            S_GEN:     next = S_SHOW;
            S_SHOW:    if (cnt == CW'(SHOW_CYCLES - 1)) next = S_WAIT_IN;
            S_WAIT_IN: begin
                if (accept) begin
                    next = S_CHECK;
                end
`ifdef MEMGAME_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    next = S_FAIL;
                end
`endif
            end
            S_CHECK:   next = (entry == target_q) ? S_PASS : S_FAIL;
            S_PASS:    if (cnt == CW'(RESULT_CYCLES - 1))
                           next = (round == 4'(NUM_ROUNDS)) ? S_END : S_GEN;
            S_FAIL:    if (cnt == CW'(RESULT_CYCLES - 1))
                           next = (lives == 2'd0) ? S_END : S_GEN;
            S_END:     if (start) next = S_GEN;
            default:   next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            armed     <= 1'b0;
            target_q  <= '0;
            entry     <= '0;
            round     <= '0;
            lives     <= '0;
            game_won  <= 1'b0;
            game_lost <= 1'b0;
        end else begin
            state <= next;
            armed <= (state == S_WAIT_IN);

            // One shared counter; any state change restarts it from zero.
            if (next != state) begin
                cnt <= '0;
            end else if (state == S_SHOW || state == S_PASS || state == S_FAIL
`ifdef MEMGAME_TIMEOUT_EN
                         || state == S_WAIT_IN
`endif
                        ) begin
                cnt <= cnt + 1'b1;
            end

            if ((state == S_IDLE || state == S_END) && start) begin
                round     <= '0;
                lives     <= 2'(MAX_LIVES);
                game_won  <= 1'b0;
                game_lost <= 1'b0;
            end

            if (state == S_GEN) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    target_q[4*k +: 4] <= fold_digit(rnd[4*k +: 4]);
                end
            end

            if (accept) begin
                entry <= bus.key_value;
            end

            if (next == S_PASS && state != S_PASS && round != 4'hF) begin
                round <= round + 4'd1;
            end
            if (next == S_FAIL && state != S_FAIL && lives != 2'd0) begin
                lives <= lives - 2'd1;
            end

            if (next == S_END && state == S_PASS) game_won  <= 1'b1;
            if (next == S_END && state == S_FAIL) game_lost <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// tb_memory_game_ctrl: directed self-checking bench for memory_game_ctrl
// (SHOW_CYCLES=8, RESULT_CYCLES=4, TIMEOUT_CYCLES=20, NUM_ROUNDS=2, MAX_LIVES=3).
// Timeout section follows MEMGAME_TIMEOUT_EN.
module tb_memory_game_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] round;
    logic [1:0] lives;
    logic       result_pass, result_fail, game_won, game_lost;
    logic [2:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    memory_game_ctrl_if bus ();

    memory_game_ctrl #(
        .SHOW_CYCLES    (8),
        .RESULT_CYCLES  (4),
        .TIMEOUT_CYCLES (20),
        .NUM_ROUNDS     (2),
        .MAX_LIVES      (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus),
        .round       (round),
        .lives       (lives),
        .result_pass (result_pass),
        .result_fail (result_fail),
        .game_won    (game_won),
        .game_lost   (game_lost),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_digits(input string tag);
        logic [15:0] t;
        logic        ok;
        t  = bus.target;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (t[4*k +: 4] > 4'd9) ok = 1'b0;
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    // Advance until WAIT_IN is reached, then one more cycle past the kbd_clr cycle.
    task automatic goto_armed(input string tag);
        int n;
        n = 0;
        while (state_dbg != 3'd3 && n < 60) begin
            tick();
            n++;
        end
        check(tag, {29'd0, state_dbg}, 32'd3);
        tick();
    endtask

    // Present an entry, then step to the first result cycle.
    task automatic enter(input logic [15:0] v);
        bus.key_value = v;
        bus.key_ready = 1'b1;
        tick();
        bus.key_ready = 1'b0;
        tick();
    endtask

    task automatic wait_result_end();
        int n;
        n = 0;
        while ((result_pass || result_fail) && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        start         = 1'b0;
        bus.key_ready = 1'b0;
        bus.key_value = 16'h0000;
        tick();
        tick();

        // Reset state
        check("rst_state", {29'd0, state_dbg}, 32'd0);
        check("rst_lives", {30'd0, lives}, 32'd0);
        check("rst_round", {28'd0, round}, 32'd0);
        check("rst_target", {16'd0, bus.target}, 32'd0);
        check("rst_flags", {26'd0, result_pass, result_fail, game_won, game_lost,
                            bus.show_target, bus.kbd_clr}, 32'd0);

        rst = 1'b0;
        tick();
        check("idle_hold", {29'd0, state_dbg}, 32'd0);

        // Start: GEN for one cycle, then SHOW for exactly 8 cycles
        pulse_start();
        check("gen_state", {29'd0, state_dbg}, 32'd1);
        check("gen_lives", {30'd0, lives}, 32'd3);
        tick();
        check("show_state", {29'd0, state_dbg}, 32'd2);
        check_digits("digits_0");
        n = 0;
        while (bus.show_target && n < 50) begin
            n++;
            tick();
        end
        check("show_len", n, 32'd8);
        check("wait_entry", {29'd0, state_dbg}, 32'd3);
        check("kbd_clr_on", {31'd0, bus.kbd_clr}, 32'd1);

        // key_ready on the kbd_clr cycle is ignored
        bus.key_value = bus.target;
        bus.key_ready = 1'b1;
        tick();
        bus.key_ready = 1'b0;
        check("kclr_ignore", {29'd0, state_dbg}, 32'd3);
        check("kbd_clr_off", {31'd0, bus.kbd_clr}, 32'd0);

        // start during WAIT_IN is ignored
        pulse_start();
        check("start_ign", {29'd0, state_dbg}, 32'd3);

        // Correct entry: CHECK next cycle, PASS the cycle after, held 4 cycles
        bus.key_value = bus.target;
        bus.key_ready = 1'b1;
        tick();
        bus.key_ready = 1'b0;
        check("check_state", {29'd0, state_dbg}, 32'd4);
        check("pass_early", {31'd0, result_pass}, 32'd0);
        tick();
        check("pass_flag", {31'd0, result_pass}, 32'd1);
        check("pass_round", {28'd0, round}, 32'd1);
        check("pass_lives", {30'd0, lives}, 32'd3);
        n = 0;
        while (result_pass && n < 20) begin
            n++;
            tick();
        end
        check("pass_len", n, 32'd4);
        check("pass_to_gen", {29'd0, state_dbg}, 32'd1);

        // key_ready during SHOW is ignored
        tick();
        bus.key_value = bus.target;
        bus.key_ready = 1'b1;
        tick();
        bus.key_ready = 1'b0;
        check("show_kr_ign", {29'd0, state_dbg}, 32'd2);
        check_digits("digits_1");

        // Wrong entry: FAIL, lives 3->2, round unchanged, new GEN
        goto_armed("reach_w1");
        enter(bus.target ^ 16'h0001);
        check("fail_flag", {31'd0, result_fail}, 32'd1);
        check("fail_lives", {30'd0, lives}, 32'd2);
        check("fail_round", {28'd0, round}, 32'd1);
        wait_result_end();
        check("fail_to_gen", {29'd0, state_dbg}, 32'd1);

        // Second pass wins
        goto_armed("reach_w2");
        enter(bus.target);
        check("pass2_flag", {31'd0, result_pass}, 32'd1);
        wait_result_end();
        check("won_state", {29'd0, state_dbg}, 32'd7);
        check("won_flag", {30'd0, game_won, game_lost}, 32'd2);
        check("won_round", {28'd0, round}, 32'd2);

        // Restart from END
        pulse_start();
        check("restart_st", {29'd0, state_dbg}, 32'd1);
        check("restart_rl", {26'd0, round, lives}, {26'd0, 4'd0, 2'd3});
        check("restart_fl", {30'd0, game_won, game_lost}, 32'd0);

        // Three fails lose
        for (int i = 0; i < 3; i++) begin
            goto_armed("reach_wf");
            enter(bus.target ^ 16'h0001);
            check("lose_lives", {30'd0, lives}, 32'(2 - i));
            wait_result_end();
        end
        check("lost_state", {29'd0, state_dbg}, 32'd7);
        check("lost_flag", {30'd0, game_won, game_lost}, 32'd1);
        check("lost_round", {28'd0, round}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("lost_hold", {29'd0, state_dbg}, 32'd7);
        check("lost_hold_f", {31'd0, game_lost}, 32'd1);

        pulse_start();
        check("restart2", {28'd0, round, lives}, {28'd0, 4'd0, 2'd3});

`ifdef MEMGAME_TIMEOUT_EN
        // No entry: 20 cycles in WAIT_IN then FAIL
        n = 0;
        while (state_dbg != 3'd3 && n < 60) begin
            tick();
            n++;
        end
        n = 0;
        while (state_dbg == 3'd3 && n < 100) begin
            n++;
            tick();
        end
        check("tmo_len", n, 32'd20);
        check("tmo_fail", {31'd0, result_fail}, 32'd1);
        check("tmo_lives", {30'd0, lives}, 32'd2);
        wait_result_end();
`else
        // No entry: WAIT_IN holds indefinitely
        goto_armed("reach_w3");
        for (int i = 0; i < 1000; i++) tick();
        check("no_tmo", {29'd0, state_dbg}, 32'd3);
        check("no_tmo_lv", {30'd0, lives}, 32'd3);
        enter(bus.target);
        wait_result_end();
`endif

        // Asynchronous reset mid-SHOW, observed before any clock edge
        n = 0;
        while (state_dbg != 3'd2 && n < 60) begin
            tick();
            n++;
        end
        check("reach_show", {29'd0, state_dbg}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", {29'd0, state_dbg}, 32'd0);
        check("arst_vals", {12'd0, bus.target, round, lives, 2'd0},
                           32'd0);
        check("arst_flags", {26'd0, result_pass, result_fail, game_won, game_lost,
                             bus.show_target, bus.kbd_clr}, 32'd0);
        tick();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_game_ctrl.md
Name: memory_game_ctrl

Overview:
- Round sequencer for the memorization game; sits between the PS/2 keyboard receiver (4-digit entry, ready pulse) and the display path.
- Generates a 4-digit BCD target, shows it for a fixed time, then clears and arms the keyboard and waits for the player's 4-digit entry.
- Compares the entry with the target and tracks rounds, lives, win and loss.

Parameters:
- SHOW_CYCLES, 200000000, cycles the target stays visible (2 s at 100 MHz); must be >= 1.
- RESULT_CYCLES, 100000000, cycles the pass/fail flag is held; must be >= 1.
- TIMEOUT_CYCLES, 1000000000, input-window limit in cycles; used only with the optional feature.
- NUM_ROUNDS, 8, passes needed to win; range 1..15.
- MAX_LIVES, 3, fails allowed before loss; range 1..3.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse (debounced button); starts or restarts a game
- key_ready  in  1  single-cycle pulse from the keyboard receiver: 4 digits captured
- key_value  in  16  4 BCD digits; [3:0] is the first key typed
- kbd_clr  out  1  one-cycle pulse that resets the keyboard receiver's partial entry
- target  out  16  current 4-digit BCD target; [3:0] is the first digit to type
- show_target  out  1  high while the display must show target
- round  out  4  passes so far in this game
- lives  out  2  remaining lives
- result_pass  out  1  high during the PASS hold
- result_fail  out  1  high during the FAIL hold
- game_won  out  1  high in WIN
- game_lost  out  1  high in LOSE
- state_dbg  out  3  current state encoding

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0 (lives=0, target=0); counters 0. Takes effect immediately, including mid-round.
- States: IDLE=0, GEN=1, SHOW=2, WAIT_IN=3, CHECK=4, PASS=5, FAIL=6, END=7. In END, game_won or game_lost tells WIN from LOSE.
- IDLE: start -> GEN; load round=0, lives=MAX_LIVES.
- GEN, 1 cycle:
  - target digit k = LFSR nibble k; a value >= 10 maps to value-10.
  - Go to SHOW; clear the counter.
- SHOW: show_target=1; counter counts to SHOW_CYCLES-1, then -> WAIT_IN.
- WAIT_IN:
  - kbd_clr=1 on the first cycle in WAIT_IN only.
  - A key_ready on that first cycle is ignored, since the receiver is being cleared.
  - Any later key_ready -> CHECK; key_value is latched on that edge.
- CHECK, 1 cycle: latched entry == target -> PASS, else -> FAIL. Full 16-bit equality.
- Latency: key_ready accepted at edge N -> result flag high from edge N+2.
- PASS: round+1 on entry; hold RESULT_CYCLES; then round==NUM_ROUNDS -> END (game_won=1), else -> GEN.
- FAIL: lives-1 on entry; hold RESULT_CYCLES; then lives==0 -> END (game_lost=1), else -> GEN. A fail always gets a new target.
- END: flags held; start -> GEN with round=0, lives=MAX_LIVES, flags cleared.
- start in any state other than IDLE/END: ignored.
- key_ready outside WAIT_IN: ignored.
- LFSR free-runs every cycle after reset, so the target depends on start timing.
- round and lives saturate; they never wrap.

Optional Feature:
- Macro MEMGAME_TIMEOUT_EN.
- Defined: a counter runs in WAIT_IN. If TIMEOUT_CYCLES cycles pass with no accepted key_ready, go to FAIL directly (skip CHECK); the counter clears on leaving WAIT_IN.
- Not defined: WAIT_IN waits forever; the timeout counter and the TIMEOUT_CYCLES logic are absent.

Decomposition:
- Package memgame_pkg holds:
  - state encodings as localparams;
  - the digit-fold function (4-bit to BCD, value >= 10 maps to value-10);
  - the BCD width constant, 16.
- Sub-module lfsr16:
  - Galois LFSR, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1 on rst;
  - output q[15:0]; never all-zero.
- Counters are sized with $clog2 of the largest parameter in use.

Test Plan (bench parameters: SHOW_CYCLES=8, RESULT_CYCLES=4, NUM_ROUNDS=2, MAX_LIVES=3, TIMEOUT_CYCLES=20):
- start pulse -> GEN 1 cycle, show_target high exactly 8 cycles, kbd_clr high exactly 1 cycle at WAIT_IN entry; every target nibble <= 9.
- In WAIT_IN, key_value=target with key_ready -> result_pass 2 cycles later for 4 cycles, round 0->1, lives stays 3, new GEN follows.
- key_value=target^16'h0001 -> result_fail, lives 3->2, round unchanged; three fails -> game_lost=1, lives=0, state_dbg=7 held until start.
- Two consecutive passes -> game_won=1; a start in END -> round=0, lives=3, flags cleared.
- key_ready during SHOW, and on the kbd_clr cycle, is ignored (state unchanged); start during WAIT_IN is ignored; rst asserted mid-SHOW -> all outputs 0 with no clock edge.
- With MEMGAME_TIMEOUT_EN, no key for 20 cycles in WAIT_IN -> FAIL, lives-1; without the macro, no transition after 1000 cycles.
